// File: rtl/fcl_pkg.sv
// rtl/fcl_pkg.sv - shared types and constants for the FCL activation buffer writer
//
// Purpose: state encoding for the write controller, default layer geometry,
//          and a word-count helper shared by the RTL and its bench.
package fcl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } fcl_wr_state_t;

  localparam int FCL1_NUM_NEURONS = 112;
  localparam int FCL_WORD_W       = 16;

  // Number of buffer words needed to hold n bits packed w per word.
  function automatic int num_words(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

endpackage

// File: rtl/fcl_bit_packer.sv
// rtl/fcl_bit_packer.sv - LSB-first serial-to-word packer for the FCL writer
//
// Purpose: collects accepted bits into a WORD_W-bit pack register, LSB first,
//          and flags the accept that completes a word.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   clear_i      zero pack register and bit count (frame start)
//   accept_i     a bit is accepted this cycle
//   bit_i        the accepted bit
//   last_i       the accepted bit is the final neuron of the frame
//   word_done_o  this accept completes a word (full or final partial)
//   word_o       pack register with the current bit merged in
module fcl_bit_packer
  import fcl_pkg::*;
#(
  parameter int WORD_W = FCL_WORD_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic              bit_i,
  input  logic              last_i,
  output logic              word_done_o,
  output logic [WORD_W-1:0] word_o
);

  localparam int BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] pack_q, pack_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;

  always_comb begin
    word_o            = pack_q;
    word_o[bit_cnt_q] = bit_i;
    word_done_o       = accept_i && ((bit_cnt_q == BCW'(WORD_W - 1)) || last_i);

    pack_d    = pack_q;
    bit_cnt_d = bit_cnt_q;
    if (clear_i || word_done_o) begin
      // Clearing on completion is what keeps the unused upper bits of a
      // partial final word at zero.
      pack_d    = '0;
      bit_cnt_d = '0;
    end else if (accept_i) begin
      pack_d    = word_o;
      bit_cnt_d = bit_cnt_q + BCW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pack_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      pack_q    <= pack_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/fcl_write_controller.sv
// rtl/fcl_write_controller.sv - writer side of the FCL activation buffer
//
// Purpose: accepts one binarized neuron output per handshake, packs them into
//          WORD_W-bit words and writes them to consecutive addresses from 0,
//          then pulses oWr_DONE.
// Ports:
//   iCLK, iRST           clock; synchronous active-high reset
//   iSTART               frame start request (honoured only in IDLE)
//   iBIT_VALID, iBIT     serial bit stream; accepted when iBIT_VALID && oREADY
//   oREADY               high in COLLECT
//   oWr_EN/ADDR/DATA     buffer write port, one strobe per word
//   oWr_DONE             one-cycle frame-complete pulse
//   oBUSY                high outside IDLE
module fcl_write_controller
  import fcl_pkg::*;
#(
  parameter int NUM_NEURONS = FCL1_NUM_NEURONS,
  parameter int WORD_W      = FCL_WORD_W,
  parameter int ADDR_W      = 9
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic              iBIT_VALID,
  input  logic              iBIT,
  output logic              oREADY,
  output logic              oWr_EN,
  output logic [ADDR_W-1:0] oWr_ADDR,
  output logic [WORD_W-1:0] oWr_DATA,
  output logic              oWr_DONE,
  output logic              oBUSY
);

  localparam int NCW = $clog2(NUM_NEURONS + 1);

  fcl_wr_state_t     state_q, state_d;
  logic [NCW-1:0]    neuron_cnt_q;
  logic [ADDR_W-1:0] word_cnt_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [WORD_W-1:0] wr_data_q;

  logic              accept;
  logic              last_neuron;
  logic              start_frame;
  logic              word_done;
  logic [WORD_W-1:0] packed_word;

  assign accept      = iBIT_VALID && (state_q == COLLECT);
  assign last_neuron = (neuron_cnt_q == NCW'(NUM_NEURONS - 1));
  assign start_frame = (state_q == IDLE) && iSTART;

  fcl_bit_packer #(
    .WORD_W(WORD_W)
  ) u_packer (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .clear_i    (start_frame),
    .accept_i   (accept),
    .bit_i      (iBIT),
    .last_i     (last_neuron),
    .word_done_o(word_done),
    .word_o     (packed_word)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (iSTART) state_d = COLLECT;
      COLLECT: if (accept && last_neuron) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= IDLE;
      neuron_cnt_q <= '0;
      word_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= word_done;

      if (start_frame) begin
        neuron_cnt_q <= '0;
      end else if (accept) begin
        neuron_cnt_q <= neuron_cnt_q + NCW'(1);
      end

      if (start_frame) begin
        word_cnt_q <= '0;
      end else if (word_done) begin
        word_cnt_q <= word_cnt_q + ADDR_W'(1);
      end

      // Address and data hold their last values between writes.
      if (word_done) begin
        wr_addr_q <= word_cnt_q;
        wr_data_q <= packed_word;
      end
    end
  end

  assign oREADY   = (state_q == COLLECT);
  assign oWr_EN   = wr_en_q;
  assign oWr_ADDR = wr_addr_q;
  assign oWr_DATA = wr_data_q;
  assign oWr_DONE = (state_q == DONE);
  assign oBUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_fcl_write_controller.sv
// tb/tb_fcl_write_controller.sv - scoreboard bench for fcl_write_controller
module tb_fcl_write_controller;
  import fcl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start, bvalid, bdata;
  logic [2:0] ready, wr_en, done, busy;
  logic [8:0]  wr_addr [3];
  logic [15:0] wr_data [3];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int nwr [3] = '{0, 0, 0};

  typedef struct {
    int          inst;
    logic [8:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fcl_write_controller dut0 (
    .iCLK(clk), .iRST(rst), .iSTART(start[0]), .iBIT_VALID(bvalid[0]), .iBIT(bdata[0]),
    .oREADY(ready[0]), .oWr_EN(wr_en[0]), .oWr_ADDR(wr_addr[0]), .oWr_DATA(wr_data[0]),
    .oWr_DONE(done[0]), .oBUSY(busy[0])
  );

  fcl_write_controller #(.NUM_NEURONS(20), .WORD_W(16), .ADDR_W(9)) dut1 (
    .iCLK(clk), .iRST(rst), .iSTART(start[1]), .iBIT_VALID(bvalid[1]), .iBIT(bdata[1]),
    .oREADY(ready[1]), .oWr_EN(wr_en[1]), .oWr_ADDR(wr_addr[1]), .oWr_DATA(wr_data[1]),
    .oWr_DONE(done[1]), .oBUSY(busy[1])
  );

  fcl_write_controller #(.NUM_NEURONS(1), .WORD_W(16), .ADDR_W(9)) dut2 (
    .iCLK(clk), .iRST(rst), .iSTART(start[2]), .iBIT_VALID(bvalid[2]), .iBIT(bdata[2]),
    .oREADY(ready[2]), .oWr_EN(wr_en[2]), .oWr_ADDR(wr_addr[2]), .oWr_DATA(wr_data[2]),
    .oWr_DONE(done[2]), .oBUSY(busy[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pat_bit(input int pat, input int k);
    case (pat)
      0:       return bit'(k % 2);
      1:       return 1'b1;
      default: return (k % 3) == 0;
    endcase
  endfunction

  // Write monitor: every write strobe must match the head of the scoreboard,
  // including the cycle it was predicted for.
  always @(negedge clk) begin
    wr_t e;
    for (int i = 0; i < 3; i++) begin
      if (wr_en[i] === 1'b1) begin
        nwr[i]++;
        if (exp_q.size() == 0) begin
          check("spurious_wr", 32'(i + 1), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_inst", 32'(i), 32'(e.inst));
          check("wr_addr", 32'(wr_addr[i]), 32'(e.addr));
          check("wr_data", 32'(wr_data[i]), 32'(e.data));
          check("wr_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Drives one frame on instance inst. Stops after stop_at bits (used for the
  // mid-frame reset); otherwise runs through FLUSH/DONE and checks the tail.
  task automatic run_frame(input int inst, input int n, input int stop_at, input int pat,
                           input bit bubbles, input bit noise);
    logic [15:0] word;
    int bpos, widx, k, c, wr0;
    bit b;
    word = '0; bpos = 0; widx = 0; k = 0; c = 0;
    wr0 = nwr[inst];
    tick(); start[inst] = 1'b1;
    tick(); start[inst] = 1'b0;
    while (k < stop_at) begin
      if (bubbles && (c % 3 == 2)) begin
        bvalid[inst] = 1'b0;
      end else begin
        b = pat_bit(pat, k);
        bvalid[inst] = 1'b1;
        bdata[inst]  = b;
        word[bpos]   = b;
        bpos++;
        if (bpos == 16 || k == n - 1) begin
          exp_q.push_back('{inst, widx[8:0], word, cyc + 1});
          word = '0; bpos = 0; widx++;
        end
        k++;
      end
      start[inst] = noise && (c == 40);
      @(negedge clk);
      check("ready_collect", 32'(ready[inst]), 32'd1);
      tick();
      c++;
    end
    bvalid[inst] = 1'b0;
    start[inst]  = 1'b0;
    if (stop_at < n) return;
    @(negedge clk);
    check("flush_ready", 32'(ready[inst]), 32'd0);
    check("flush_busy", 32'(busy[inst]), 32'd1);
    check("flush_done", 32'(done[inst]), 32'd0);
    tick();
    if (noise) start[inst] = 1'b1;
    @(negedge clk);
    check("done_pulse", 32'(done[inst]), 32'd1);
    check("done_busy", 32'(busy[inst]), 32'd1);
    tick();
    start[inst] = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy[inst]), 32'd0);
    check("idle_done", 32'(done[inst]), 32'd0);
    tick();
    @(negedge clk);
    check("stay_idle", 32'(busy[inst]), 32'd0);
    check("num_writes", 32'(nwr[inst] - wr0), 32'(num_words(n, 16)));
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = '0; bvalid = '0; bdata = '0;
    repeat (3) tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", 32'(ready[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_wr_en", 32'(wr_en[i]), 32'd0);
      check("rst_done", 32'(done[i]), 32'd0);
      check("rst_addr", 32'(wr_addr[i]), 32'd0);
      check("rst_data", 32'(wr_data[i]), 32'd0);
    end
    tick(); rst = 1'b0;

    // Default frame, alternating bits: seven 16'hAAAA words.
    run_frame(0, 112, 112, 0, 1'b0, 1'b0);
    // Short frame, all ones: 16'hFFFF then 16'h000F.
    run_frame(1, 20, 20, 1, 1'b0, 1'b0);
    // Bubbles every third cycle.
    run_frame(0, 112, 112, 2, 1'b1, 1'b0);

    // Valid asserted while idle must not be accepted.
    bvalid[0] = 1'b1; bdata[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("idle_ready", 32'(ready[0]), 32'd0);
      check("idle_nobusy", 32'(busy[0]), 32'd0);
    end
    bvalid[0] = 1'b0;
    // iSTART pulsed mid-COLLECT and in DONE.
    run_frame(0, 112, 112, 0, 1'b0, 1'b1);

    // Single-neuron frame.
    run_frame(2, 1, 1, 1, 1'b0, 1'b0);

    // Mid-frame reset after 40 accepts, valid kept high.
    run_frame(0, 112, 40, 0, 1'b0, 1'b0);
    bvalid[0] = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("mrst_ready", 32'(ready[0]), 32'd0);
      check("mrst_busy", 32'(busy[0]), 32'd0);
      check("mrst_done", 32'(done[0]), 32'd0);
      check("mrst_wr_en", 32'(wr_en[0]), 32'd0);
      check("mrst_addr", 32'(wr_addr[0]), 32'd0);
      check("mrst_data", 32'(wr_data[0]), 32'd0);
    end
    tick();
    rst = 1'b0; bvalid[0] = 1'b0;
    check("mrst_sb_drained", 32'(exp_q.size()), 32'd0);
    run_frame(0, 112, 112, 1, 1'b0, 1'b0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
